// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Divide-by-zero and signed overflow resolve at acceptance with the ISA-mandated results.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CntLast = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            remOp_q, remOp_d;
  logic            negQ_q, negQ_d;
  logic            negR_q, negR_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            isSigned;
  logic            dividendNeg;
  logic            divisorNeg;
  logic [XLEN-1:0] absDividend;
  logic [XLEN-1:0] absDivisor;
  logic            divByZero;
  logic            overflow;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] stepRem;
  logic [XLEN-1:0] stepQuo;
  logic [XLEN-1:0] quoFinal;
  logic [XLEN-1:0] remFinal;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

  // Operand decode for acceptance; op[0] = 0 selects the signed variants.
  always_comb begin
    isSigned    = ~op[0];
    dividendNeg = isSigned & dividend[XLEN-1];
    divisorNeg  = isSigned & divisor[XLEN-1];
    absDividend = dividendNeg ? (~dividend + 1'b1) : dividend;
    absDivisor  = divisorNeg ? (~divisor + 1'b1) : divisor;
    divByZero   = (divisor == '0);
    overflow    = isSigned && (dividend == MinNeg) && (divisor == '1);
  end

  // One restoring step: the remainder stays below the divisor, so XLEN bits hold it
  // between steps while the trial subtraction needs the extra borrow bit.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, dvsr_q};
    if (!trial[XLEN]) begin
      stepRem = trial[XLEN-1:0];
      stepQuo = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      stepRem = shifted[XLEN-1:0];
      stepQuo = {quo_q[XLEN-2:0], 1'b0};
    end
    quoFinal = negQ_q ? (~stepQuo + 1'b1) : stepQuo;
    remFinal = negR_q ? (~stepRem + 1'b1) : stepRem;
  end

  always_comb begin
    state_d  = state_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    cnt_d    = cnt_q;
    remOp_d  = remOp_q;
    negQ_d   = negQ_q;
    negR_d   = negR_q;
    result_d = result_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            remOp_d = op[1];
            if (divByZero) begin
              state_d  = DONE;
              result_d = op[1] ? dividend : '1;
            end else if (overflow) begin
              state_d  = DONE;
              result_d = op[1] ? '0 : dividend;
            end else begin
              state_d = CALC;
              cnt_d   = '0;
              quo_d   = absDividend;
              dvsr_d  = absDivisor;
              rem_d   = '0;
              negQ_d  = dividendNeg ^ divisorNeg;
              negR_d  = dividendNeg;
            end
          end
        end
        CALC: begin
          rem_d = stepRem;
          quo_d = stepQuo;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CntLast) begin
            state_d  = DONE;
            result_d = remOp_q ? remFinal : quoFinal;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      remOp_q  <= 1'b0;
      negQ_q   <= 1'b0;
      negR_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      cnt_q    <= cnt_d;
      remOp_q  <= remOp_d;
      negQ_q   <= negQ_d;
      negR_q   <= negR_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit: results, latency, backpressure,
// flush, and reset behaviour against hand-computed values and a reference model.
module tb_div_unit;

  localparam logic [31:0] MinNeg = 32'h8000_0000;
  localparam logic [1:0] OpDiv  = 2'b00;
  localparam logic [1:0] OpDivu = 2'b01;
  localparam logic [1:0] OpRem  = 2'b10;
  localparam logic [1:0] OpRemu = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int testsRun;
  int testsFailed;

  div_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one operation at a negedge; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    op       = opIn;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Latency counts the accepting edge as 1; bounded so a stuck DUT still ends.
  task automatic waitResult(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic doOp(input string tag, input logic [1:0] opIn, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] expRes, input int expLat);
    int lat;
    applyStimulus(opIn, a, b);
    waitResult(lat);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_res"}, result, expRes);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] refModel(input logic [1:0] opIn, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return opIn[1] ? a : 32'hFFFF_FFFF;
    case (opIn)
      OpDiv:   return (a == MinNeg && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
      OpDivu:  return a / b;
      OpRem:   return (a == MinNeg && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  initial begin
    int lat;
    int sel;
    logic sawValid;
    logic [1:0] rop;
    logic [31:0] ra;
    logic [31:0] rb;

    testsRun    = 0;
    testsFailed = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 2'b00;
    dividend  = '0;
    divisor   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    rst_n = 1'b1;

    doOp("divu_100_7", OpDivu, 32'd100, 32'd7, 32'd14, 33);
    doOp("remu_100_7", OpRemu, 32'd100, 32'd7, 32'd2, 33);
    doOp("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    doOp("rem_m7_2", OpRem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    doOp("div_7_m2", OpDiv, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    doOp("rem_7_m2", OpRem, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    doOp("div_m100_m7", OpDiv, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33);
    doOp("divu_max_1", OpDivu, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
    doOp("remu_max_16", OpRemu, 32'hFFFF_FFFF, 32'd16, 32'd15, 33);
    doOp("divu_5_7", OpDivu, 32'd5, 32'd7, 32'd0, 33);
    doOp("div_min_2", OpDiv, MinNeg, 32'd2, 32'hC000_0000, 33);

    doOp("div_by0", OpDiv, 32'd42, 32'd0, 32'hFFFF_FFFF, 1);
    doOp("divu_by0", OpDivu, 32'd42, 32'd0, 32'hFFFF_FFFF, 1);
    doOp("remu_by0", OpRemu, 32'h1234, 32'd0, 32'h1234, 1);
    doOp("rem_by0", OpRem, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 1);
    doOp("div_ovf", OpDiv, MinNeg, 32'hFFFF_FFFF, MinNeg, 1);
    doOp("rem_ovf", OpRem, MinNeg, 32'hFFFF_FFFF, 32'd0, 1);
    doOp("divu_noovf", OpDivu, MinNeg, 32'hFFFF_FFFF, 32'd0, 33);

    // Backpressure: result held, new requests ignored while DONE waits.
    out_ready = 1'b0;
    applyStimulus(OpDivu, 32'd50, 32'd5);
    waitResult(lat);
    checkOutput("bp_lat", 32'(lat), 32'd33);
    checkOutput("bp_res", result, 32'd10);
    in_valid = 1'b1;
    op       = OpDivu;
    dividend = 32'd99;
    divisor  = 32'd3;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp_hold_valid%0d", i), {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("bp_hold_res%0d", i), result, 32'd10);
      checkOutput($sformatf("bp_hold_ready%0d", i), {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("bp_release_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("bp_release_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("bp_no_accept", {31'd0, in_ready}, 32'd1);
    checkOutput("bp_res_kept", result, 32'd10);

    // Flush during CALC cycle 12.
    applyStimulus(OpDivu, 32'd1000, 32'd3);
    repeat (11) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush_res_kept", result, 32'd10);
    sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("flush_no_valid", {31'd0, sawValid}, 32'd0);
    doOp("divu_9_3", OpDivu, 32'd9, 32'd3, 32'd3, 33);

    // Flush beats a simultaneous request in IDLE.
    @(negedge clk);
    in_valid = 1'b1;
    flush    = 1'b1;
    op       = OpDivu;
    dividend = 32'd8;
    divisor  = 32'd2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    checkOutput("flush_prio_ready", {31'd0, in_ready}, 32'd1);

    // Reset mid-operation.
    applyStimulus(OpDivu, 32'd77, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("rst_mid_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_mid_result", result, 32'd0);

    // Randomized regression against the reference model.
    for (int i = 0; i < 200; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        rb = 32'd0;
      end else if (sel == 1) begin
        ra = MinNeg;
        rb = 32'hFFFF_FFFF;
      end else if (sel < 6) begin
        rb = 32'($urandom_range(1, 1000));
        if (sel == 5) rb = -rb;
      end else begin
        rb = $urandom;
      end
      doOp($sformatf("rnd%0d", i), rop, ra, rb, refModel(rop, ra, rb),
           ((rb == 32'd0) || (!rop[0] && ra == MinNeg && rb == 32'hFFFF_FFFF)) ? 1 : 33);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
